// File: rtl/coproc_link_pkg.sv
// Shared definitions for the 8-bit toggle-tag coprocessor link.
// Holds the master FSM state encoding and the default link geometry
// (operand/result widths and handshake timing) that both ends of the link
// are built against.
package coproc_link_pkg;

  localparam int DATA_WIDTH_DEF    = 8;
  localparam int RESULT_WIDTH_DEF  = 4;
  localparam int SETTLE_CYCLES_DEF = 2;
  localparam int RESULT_WAIT_DEF   = 12;
  localparam int RESET_HOLD_DEF    = 4;

  typedef enum logic [1:0] {
    HOLD,
    IDLE,
    SETUP,
    WAIT
  } link_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/coproc_link_master_if.sv
// Signal bundle for coproc_link_master.
//   req_*   : local operand request port (valid/ready)
//   rsp_*   : one-cycle result strobe and held result
//   busy    : master is not idle
//   link_*  : pin-level link to the remote coprocessor
// master modport is the link initiator; slave modport is the local
// requester plus the remote pins (used by a bench or enclosing wrapper).
interface coproc_link_master_if
  import coproc_link_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int RESULT_WIDTH = RESULT_WIDTH_DEF
);
  logic                    req_valid;
  logic                    req_ready;
  logic [DATA_WIDTH-1:0]   req_data;
  logic                    rsp_valid;
  logic [RESULT_WIDTH-1:0] rsp_data;
  logic                    busy;
  logic [DATA_WIDTH-1:0]   link_data;
  logic                    link_tag;
  logic                    link_reset_n;
  logic [RESULT_WIDTH-1:0] link_result;

  modport master (
    input  req_valid, req_data, link_result,
    output req_ready, rsp_valid, rsp_data, busy,
           link_data, link_tag, link_reset_n
  );

  modport slave (
    output req_valid, req_data, link_result,
    input  req_ready, rsp_valid, rsp_data, busy,
           link_data, link_tag, link_reset_n
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, parameterized width, async active-high reset to 0.
//   clock, reset : sampling clock / async reset
//   d            : asynchronous input
//   q            : synchronized output, two clock edges behind d
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      // stage p0 -> p1
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;
endmodule

// File: rtl/coproc_link_master.sv
// Initiator side of the toggle-tag coprocessor link.
// Accepts one operand from the local valid/ready port, presents it on
// link_data, flips link_tag after SETTLE_CYCLES, then after RESULT_WAIT
// cycles captures the synchronized remote result and strobes rsp_valid.
// Also sequences the remote's active-low reset out of local reset.
//   clock, reset : sole clock, async active-high reset
//   bus          : coproc_link_master_if.master (request, response, link pins)
module coproc_link_master
  import coproc_link_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int RESULT_WIDTH  = RESULT_WIDTH_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int RESULT_WAIT   = RESULT_WAIT_DEF,
  parameter int RESET_HOLD    = RESET_HOLD_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  coproc_link_master_if.master bus
);
  localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, RESULT_WAIT, RESET_HOLD)) + 1;

  link_state_e             state, state_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic [DATA_WIDTH-1:0]   link_data_q, link_data_d;
  logic                    tag_q, tag_d;
  logic                    rst_n_q, rst_n_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [RESULT_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [RESULT_WIDTH-1:0] result_sync;

  // The remote result is never trusted combinationally; it always crosses
  // two flops, which is why RESULT_WAIT must exceed remote latency by 2.
  sync_2ff #(.WIDTH(RESULT_WIDTH)) u_result_sync (
    .clock (clock),
    .reset (reset),
    .d     (bus.link_result),
    .q     (result_sync)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HOLD;
      cnt         <= CNT_W'(RESET_HOLD - 1);
      link_data_q <= '0;
      tag_q       <= 1'b0;
      rst_n_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      link_data_q <= link_data_d;
      tag_q       <= tag_d;
      rst_n_q     <= rst_n_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    link_data_d = link_data_q;
    tag_d       = tag_q;
    rst_n_d     = rst_n_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    unique case (state)
      HOLD: begin
        if (cnt == '0) begin
          state_d = IDLE;
          rst_n_d = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      IDLE: begin
        if (bus.req_valid) begin
          link_data_d = bus.req_data;
          cnt_d       = CNT_W'(SETTLE_CYCLES - 1);
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          tag_d   = ~tag_q;
          cnt_d   = CNT_W'(RESULT_WAIT - 1);
          state_d = WAIT;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          rsp_data_d  = result_sync;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.link_data    = link_data_q;
  assign bus.link_tag     = tag_q;
  assign bus.link_reset_n = rst_n_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
endmodule

// File: tb/tb_coproc_link_master.sv
// Scoreboard bench for coproc_link_master with a behavioural remote.
module tb_coproc_link_master;
  import coproc_link_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  coproc_link_master_if #(.DATA_WIDTH(DATA_WIDTH_DEF), .RESULT_WIDTH(RESULT_WIDTH_DEF)) bus ();

  coproc_link_master dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural remote: result valid 7 cycles after it sees the tag edge
  function automatic logic [3:0] remote_fn(input logic [7:0] d);
    logic [7:0] s;
    s = 8'(d * d);
    s = s + 8'd3;
    return 4'(s * s);
  endfunction

  logic [7:0] r_d1, r_d2;
  logic       r_tag_seen;
  int         r_cnt;
  logic [3:0] r_val, r_res;
  logic       ovr_en;
  logic [3:0] ovr_val;

  always @(posedge clock or negedge bus.link_reset_n) begin
    if (!bus.link_reset_n) begin
      r_d1 <= '0; r_d2 <= '0; r_tag_seen <= 1'b0; r_cnt <= 0; r_val <= '0; r_res <= '0;
    end else begin
      r_d1       <= bus.link_data;
      r_d2       <= r_d1;
      r_tag_seen <= bus.link_tag;
      if (bus.link_tag != r_tag_seen) begin
        r_val <= remote_fn(r_d2);
        r_cnt <= 6;
      end else if (r_cnt > 0) begin
        if (r_cnt == 1) r_res <= r_val;
        r_cnt <= r_cnt - 1;
      end
    end
  end

  assign bus.link_result = ovr_en ? ovr_val : r_res;

  // Acceptance tracking
  int cyc = 0;
  int n_acc = 0;
  int last_acc = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!reset && bus.req_valid && bus.req_ready) begin
      n_acc    <= n_acc + 1;
      last_acc <= cyc;
    end
  end

  // Scoreboard
  typedef struct {
    logic [3:0] data;
    logic       tag;
  } exp_t;
  exp_t exp_q[$];
  logic exp_tag;

  task automatic push_exp(input logic [3:0] d);
    exp_t e;
    exp_tag = ~exp_tag;
    e.data  = d;
    e.tag   = exp_tag;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset && bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL rsp_unexpected: got rsp_data 0x%0h with no response outstanding", bus.rsp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        check("rsp_tag", 32'(bus.link_tag), 32'(e.tag));
        check("rsp_latency", 32'((cyc - 1) - last_acc), 32'(SETTLE_CYCLES_DEF + RESULT_WAIT_DEF));
        check("rsp_req_ready", 32'(bus.req_ready), 32'd1);
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < 80) begin
      @(negedge clock);
      n++;
    end
    check("drain_in_time", 32'(n < 80), 32'd1);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    exp_tag = 1'b0;
    #1;
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    check("rst_link_reset_n", 32'(bus.link_reset_n), 32'd0);
    check("rst_link_data", 32'(bus.link_data), 32'd0);
    check("rst_link_tag", 32'(bus.link_tag), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("hold_link_reset_n", 32'(bus.link_reset_n), 32'(i == 3));
      check("hold_req_ready", 32'(bus.req_ready), 32'(i == 3));
      check("hold_link_data", 32'(bus.link_data), 32'd0);
      check("hold_link_tag", 32'(bus.link_tag), 32'd0);
    end
  endtask

  // Drive one operand at a negedge while idle; returns at the negedge after acceptance
  task automatic start_txn(input logic [7:0] d);
    bus.req_valid = 1'b1;
    bus.req_data  = d;
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("acc_link_data", 32'(bus.link_data), 32'(d));
    check("acc_busy", 32'(bus.busy), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a1, base, n;
    logic t0;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    ovr_en        = 1'b0;
    ovr_val       = '0;
    exp_tag       = 1'b0;
    @(negedge clock);
    do_reset();

    // Single operand 0x02 -> 0x1, tag 0->1 after T+2
    push_exp(4'h1);
    start_txn(8'h02);
    check("t1_tag_after_T", 32'(bus.link_tag), 32'd0);
    @(negedge clock);
    check("t1_tag_after_T1", 32'(bus.link_tag), 32'd0);
    @(negedge clock);
    check("t1_tag_after_T2", 32'(bus.link_tag), 32'd1);
    wait_drain();

    // Back-to-back with req_valid held: 0x00 then 0x04, both -> 0x9
    base = n_acc;
    push_exp(4'h9);
    bus.req_valid = 1'b1;
    bus.req_data  = 8'h00;
    @(negedge clock);
    a1 = last_acc;
    push_exp(4'h9);
    bus.req_data = 8'h04;
    n = 0;
    while (n_acc < base + 2 && n < 40) begin
      @(negedge clock);
      n++;
    end
    bus.req_valid = 1'b0;
    check("b2b_second_accept", 32'(n_acc - base), 32'd2);
    check("b2b_gap", 32'(last_acc - a1), 32'd15);
    check("b2b_link_data", 32'(bus.link_data), 32'h04);
    wait_drain();

    // Request noise during SETUP/WAIT is ignored
    base = n_acc;
    push_exp(4'h1);
    start_txn(8'h02);
    for (int i = 0; i < 12; i++) begin
      bus.req_valid = 1'b1;
      bus.req_data  = 8'(i * 37 + 5);
      @(negedge clock);
      check("noise_link_data", 32'(bus.link_data), 32'h02);
    end
    bus.req_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clock);
    check("noise_single_accept", 32'(n_acc - base), 32'd1);

    // Reset during WAIT aborts without a response
    start_txn(8'h55);
    repeat (6) @(negedge clock);
    do_reset();
    wait_drain();
    push_exp(4'h1);
    t0 = bus.link_tag;
    check("post_rst_tag_before", 32'(t0), 32'd0);
    start_txn(8'h02);
    repeat (2) @(negedge clock);
    check("post_rst_tag_after", 32'(bus.link_tag), 32'd1);
    wait_drain();

    // Synchronizer timing: change 1 cycle before capture -> old value
    ovr_en  = 1'b1;
    ovr_val = 4'hA;
    repeat (3) @(negedge clock);
    push_exp(4'hA);
    start_txn(8'h02);
    repeat (12) @(negedge clock);
    ovr_val = 4'h5;
    wait_drain();

    // Change 3 cycles before capture -> new value
    ovr_val = 4'hA;
    repeat (3) @(negedge clock);
    push_exp(4'h5);
    start_txn(8'h02);
    repeat (10) @(negedge clock);
    ovr_val = 4'h5;
    wait_drain();
    ovr_en = 1'b0;

    repeat (5) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
